// File: rtl/multdiv_pkg.sv
// Shared types and constants for the iterative multiply/divide engine.
package multdiv_pkg;

  localparam int WIDTH_DEF = 32;
  localparam int CNT_W_DEF = 6;

  typedef enum logic [2:0] {
    IDLE = 3'd0,
    MULT = 3'd1,
    DIV  = 3'd2,
    FIX  = 3'd3,
    DONE = 3'd4
  } state_t;

  localparam logic OP_MULT = 1'b0;
  localparam logic OP_DIV  = 1'b1;

endpackage

// File: rtl/multdiv_iter_ctrl_if.sv
// Start/result bundle between the operand latches, the engine and the result bank.
interface multdiv_iter_ctrl_if
  import multdiv_pkg::*;
#(
  parameter int WIDTH = WIDTH_DEF,
  parameter int CNT_W = CNT_W_DEF
);
  // Handshake: ctrl_mult/ctrl_div are one-cycle start pulses, accepted on any
  // cycle (a start while busy aborts and restarts). result/exception are valid
  // only in the single cycle result_rdy (= bank_we) is high; no back-pressure.
  logic             ctrl_mult;
  logic             ctrl_div;
  logic [WIDTH-1:0] operand_a;
  logic [WIDTH-1:0] operand_b;
  logic [WIDTH-1:0] result;
  logic             result_rdy;
  logic             exception;
  logic             busy;
  logic             bank_we;
  logic             bank_clr;
  state_t           state;
  logic [CNT_W-1:0] count;

  modport master (
    output ctrl_mult, ctrl_div, operand_a, operand_b,
    input  result, result_rdy, exception, busy, bank_we, bank_clr, state, count
  );

  modport slave (
    input  ctrl_mult, ctrl_div, operand_a, operand_b,
    output result, result_rdy, exception, busy, bank_we, bank_clr, state, count
  );

endinterface

// File: rtl/multdiv_iter_counter.sv
// Iteration counter: sync clear, enable, terminal-count flag at TERM.
module multdiv_iter_counter #(
  parameter int               CNT_W = 6,
  parameter logic [CNT_W-1:0] TERM  = '1
) (
  input  logic             clk,
  input  logic             clr_n,
  input  logic             clear,
  input  logic             en,
  output logic [CNT_W-1:0] count,
  output logic             tc
);

  always_ff @(posedge clk) begin
    if (!clr_n || clear) begin
      count <= '0;
    end else if (en) begin
      count <= count + CNT_W'(1);
    end
  end

  assign tc = (count == TERM);

endmodule

// File: rtl/multdiv_iter_ctrl.sv
// Iterative signed multiply (radix-2 Booth) / divide (non-restoring on magnitudes)
// engine driving the multdiv result bank.
module multdiv_iter_ctrl
  import multdiv_pkg::*;
#(
  parameter int WIDTH = WIDTH_DEF,
  parameter int CNT_W = CNT_W_DEF
) (
  input logic                 clk,
  input logic                 clr_n,
  multdiv_iter_ctrl_if.slave  bus
);

  state_t           state_q, state_d;
  logic             load_q;
  logic [WIDTH:0]   acc_q;
  logic [WIDTH-1:0] lo_q;
  logic             qm1_q;
  logic [WIDTH:0]   dvs_q;
  logic             neg_q;
  logic [WIDTH-1:0] result_q;
  logic             exc_q;

  logic             start, start_op, iter, cnt_tc;
  logic [CNT_W-1:0] cnt;
  logic [WIDTH:0]   add_x, add_y, add_sum;
  logic             add_sub;
  logic [WIDTH:0]   mul_acc_n;
  logic [WIDTH-1:0] mul_lo_n, div_lo_n;
  logic             mul_ovf;

  assign start    = bus.ctrl_mult | bus.ctrl_div;
  assign start_op = bus.ctrl_mult ? OP_MULT : OP_DIV;
  // The first cycle after a start (load_q) prepares operands; iterations follow.
  assign iter     = (state_q == MULT || state_q == DIV) && !load_q;

  multdiv_iter_counter #(
    .CNT_W (CNT_W),
    .TERM  (CNT_W'(WIDTH - 1))
  ) u_cnt (
    .clk   (clk),
    .clr_n (clr_n),
    .clear (start),
    .en    (iter && !cnt_tc),
    .count (cnt),
    .tc    (cnt_tc)
  );

  always_comb begin
    state_d = state_q;
    if (start) begin
      state_d = (start_op == OP_MULT) ? MULT : DIV;
    end else begin
      case (state_q)
        MULT: if (iter && cnt_tc) state_d = DONE;
        DIV: begin
          if (load_q && dvs_q == '0)  state_d = DONE;
          else if (iter && cnt_tc)    state_d = FIX;
        end
        FIX:     state_d = DONE;
        DONE:    state_d = IDLE;
        default: state_d = state_q;
      endcase
    end
  end

  // Single WIDTH+1 adder shared by Booth steps, divide steps and the remainder restore.
  always_comb begin
    add_x   = '0;
    add_y   = '0;
    add_sub = 1'b0;
    case (state_q)
      MULT: begin
        add_x = acc_q;
        case ({lo_q[0], qm1_q})
          2'b01:   add_y = dvs_q;
          2'b10: begin
            add_y   = dvs_q;
            add_sub = 1'b1;
          end
          default: add_y = '0;
        endcase
      end
      DIV: begin
        add_x   = {acc_q[WIDTH-1:0], lo_q[WIDTH-1]};
        add_y   = dvs_q;
        add_sub = ~acc_q[WIDTH];
      end
      FIX: begin
        add_x = acc_q;
        add_y = acc_q[WIDTH] ? dvs_q : '0;
      end
      default: ;
    endcase
    add_sum = add_x + (add_sub ? ~add_y : add_y) + {{WIDTH{1'b0}}, add_sub};
  end

  assign mul_acc_n = {add_sum[WIDTH], add_sum[WIDTH:1]};
  assign mul_lo_n  = {add_sum[0], lo_q[WIDTH-1:1]};
  assign div_lo_n  = {lo_q[WIDTH-2:0], ~add_sum[WIDTH]};
  assign mul_ovf   = mul_acc_n[WIDTH-1:0] != {WIDTH{mul_lo_n[WIDTH-1]}};

  always_ff @(posedge clk) begin
    if (!clr_n) begin
      state_q  <= IDLE;
      load_q   <= 1'b0;
      acc_q    <= '0;
      lo_q     <= '0;
      qm1_q    <= 1'b0;
      dvs_q    <= '0;
      neg_q    <= 1'b0;
      result_q <= '0;
      exc_q    <= 1'b0;
    end else begin
      state_q <= state_d;
      load_q  <= start;
      if (start) begin
        acc_q    <= '0;
        qm1_q    <= 1'b0;
        result_q <= '0;
        exc_q    <= 1'b0;
        if (start_op == OP_MULT) begin
          lo_q  <= bus.operand_b;
          dvs_q <= {bus.operand_a[WIDTH-1], bus.operand_a};
          neg_q <= 1'b0;
        end else begin
          lo_q  <= bus.operand_a;
          dvs_q <= {bus.operand_b[WIDTH-1], bus.operand_b};
          neg_q <= bus.operand_a[WIDTH-1] ^ bus.operand_b[WIDTH-1];
        end
      end else begin
        case (state_q)
          MULT: begin
            if (iter) begin
              acc_q <= mul_acc_n;
              lo_q  <= mul_lo_n;
              qm1_q <= lo_q[0];
              if (cnt_tc) begin
                result_q <= mul_lo_n;
                exc_q    <= mul_ovf;
              end
            end
          end
          DIV: begin
            if (load_q) begin
              lo_q  <= lo_q[WIDTH-1] ? -lo_q : lo_q;
              dvs_q <= dvs_q[WIDTH] ? -dvs_q : dvs_q;
              if (dvs_q == '0) begin
                result_q <= '0;
                exc_q    <= 1'b1;
              end
            end else begin
              acc_q <= add_sum;
              lo_q  <= div_lo_n;
            end
          end
          FIX: begin
            acc_q    <= add_sum;
            result_q <= neg_q ? -lo_q : lo_q;
            // Only |-2^(W-1)| / 1 with a positive sign leaves the top quotient bit set.
            exc_q    <= ~neg_q & lo_q[WIDTH-1];
          end
          default: ;
        endcase
      end
    end
  end

  assign bus.result     = result_q;
  assign bus.exception  = exc_q;
  assign bus.result_rdy = (state_q == DONE);
  assign bus.bank_we    = (state_q == DONE);
  assign bus.bank_clr   = load_q;
  assign bus.busy       = (state_q == MULT) || (state_q == DIV) || (state_q == FIX);
  assign bus.state      = state_q;
  assign bus.count      = cnt;

endmodule

// File: tb/tb_multdiv_iter_ctrl.sv
// Bench for multdiv_iter_ctrl: vector table, random ops vs. a reference model, corner sequences.
module tb_multdiv_iter_ctrl;
  import multdiv_pkg::*;

  localparam int W  = 32;
  localparam int CW = 6;
  localparam int XW = W + 1;

  typedef struct {
    logic [1:0]   op;
    logic [W-1:0] a;
    logic [W-1:0] b;
    logic [W-1:0] exp_res;
    logic         exp_exc;
    int           lat;
  } vec_t;

  logic clk;
  logic clr_n;
  logic chk_en;
  int   total;
  int   bad;
  logic [XW-1:0] exp_q[$];
  vec_t tbl[12];

  multdiv_iter_ctrl_if #(.WIDTH(W), .CNT_W(CW)) bus ();

  multdiv_iter_ctrl #(.WIDTH(W), .CNT_W(CW)) dut (
    .clk   (clk),
    .clr_n (clr_n),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check_val(input string nm, input logic [W-1:0] got, input logic [W-1:0] want);
    total++;
    if (got !== want) begin
      bad++;
      $display("FAIL %s got=%h want=%h", nm, got, want);
    end
  endtask

  function automatic void model(input logic [1:0] op, input logic [W-1:0] a, input logic [W-1:0] b,
                                output logic [W-1:0] r, output logic e, output int lat);
    logic signed [W-1:0]   sa, sb;
    logic signed [2*W-1:0] p;
    sa = a;
    sb = b;
    if (op[0]) begin
      p   = sa * sb;
      r   = p[W-1:0];
      e   = (p[2*W-1:W] != {W{p[W-1]}});
      lat = W + 1;
    end else if (b == '0) begin
      r = '0; e = 1'b1; lat = 1;
    end else if (a == 32'h8000_0000 && b == 32'hFFFF_FFFF) begin
      r = 32'h8000_0000; e = 1'b1; lat = W + 2;
    end else begin
      r = sa / sb; e = 1'b0; lat = W + 2;
    end
  endfunction

  task automatic pulse(input logic [1:0] op, input logic [W-1:0] a, input logic [W-1:0] b);
    @(negedge clk);
    bus.ctrl_mult = op[0];
    bus.ctrl_div  = op[1];
    bus.operand_a = a;
    bus.operand_b = b;
    @(posedge clk);
    #1;
    bus.ctrl_mult = 1'b0;
    bus.ctrl_div  = 1'b0;
  endtask

  // k counts posedges after the start edge; rdy must appear exactly at k == lat.
  task automatic run_op(input logic [1:0] op, input logic [W-1:0] a, input logic [W-1:0] b,
                        input logic [W-1:0] er, input logic ee, input int lat, input string nm);
    int k;
    bit seen;
    exp_q.push_back({ee, er});
    pulse(op, a, b);
    k = 0;
    seen = 0;
    while (!seen && k <= lat + 8) begin
      @(negedge clk);
      if (k == 0) begin
        check_val({nm, "_bank_clr_start"}, 32'(bus.bank_clr), 32'd1);
        check_val({nm, "_busy_start"}, 32'(bus.busy), 32'd1);
      end
      if (k == 1) check_val({nm, "_bank_clr_after"}, 32'(bus.bank_clr), 32'd0);
      if (bus.result_rdy === 1'b1) begin
        seen = 1;
        check_val({nm, "_busy_done"}, 32'(bus.busy), 32'd0);
        check_val({nm, "_state_done"}, 32'(bus.state), 32'(DONE));
      end else begin
        k++;
      end
    end
    total++;
    if (!seen || k != lat) begin
      bad++;
      $display("FAIL %s_latency got=%0d want=%0d seen=%0d", nm, k, lat, seen);
    end
  endtask

  // Scoreboard: every rdy pulse pops one expected {exception, result}.
  always @(negedge clk) begin
    logic [XW-1:0] e;
    if (chk_en) begin
      total++;
      if (bus.bank_we !== bus.result_rdy) begin
        bad++;
        $display("FAIL bank_we got=%b want=%b", bus.bank_we, bus.result_rdy);
      end
      if (bus.result_rdy === 1'b1) begin
        total++;
        if (exp_q.size() == 0) begin
          bad++;
          $display("FAIL unexpected_rdy got=%h want=none", {bus.exception, bus.result});
        end else begin
          e = exp_q.pop_front();
          if ({bus.exception, bus.result} !== e) begin
            bad++;
            $display("FAIL result got=exc %b res %h want=exc %b res %h",
                     bus.exception, bus.result, e[W], e[W-1:0]);
          end
        end
      end
    end
  end

  task automatic check_all_zero(input string nm);
    check_val({nm, "_result"}, bus.result, '0);
    check_val({nm, "_rdy"}, 32'(bus.result_rdy), 32'd0);
    check_val({nm, "_exc"}, 32'(bus.exception), 32'd0);
    check_val({nm, "_busy"}, 32'(bus.busy), 32'd0);
    check_val({nm, "_bank_we"}, 32'(bus.bank_we), 32'd0);
    check_val({nm, "_bank_clr"}, 32'(bus.bank_clr), 32'd0);
    check_val({nm, "_state"}, 32'(bus.state), 32'(IDLE));
    check_val({nm, "_count"}, 32'(bus.count), 32'd0);
  endtask

  initial begin
    logic [1:0]   op;
    logic [W-1:0] a, b, r;
    logic         e;
    int           lat;

    total = 0;
    bad = 0;
    chk_en = 1'b0;
    clr_n = 1'b0;
    bus.ctrl_mult = 1'b0;
    bus.ctrl_div  = 1'b0;
    bus.operand_a = '0;
    bus.operand_b = '0;

    tbl[0]  = '{2'd1, 32'd7,          32'hFFFF_FFFD, 32'hFFFF_FFEB, 1'b0, W + 1};
    tbl[1]  = '{2'd1, 32'h0001_0000,  32'h0001_0000, 32'h0000_0000, 1'b1, W + 1};
    tbl[2]  = '{2'd1, 32'hFFFF_FFFF,  32'hFFFF_FFFF, 32'h0000_0001, 1'b0, W + 1};
    tbl[3]  = '{2'd2, 32'hFFFF_FFF9,  32'd2,         32'hFFFF_FFFD, 1'b0, W + 2};
    tbl[4]  = '{2'd2, 32'd100,        32'd7,         32'd14,        1'b0, W + 2};
    tbl[5]  = '{2'd2, 32'd5,          32'd0,         32'd0,         1'b1, 1};
    tbl[6]  = '{2'd2, 32'h8000_0000,  32'hFFFF_FFFF, 32'h8000_0000, 1'b1, W + 2};
    tbl[7]  = '{2'd3, 32'd6,          32'd7,         32'd42,        1'b0, W + 1};
    tbl[8]  = '{2'd1, 32'h8000_0000,  32'h8000_0000, 32'h0000_0000, 1'b1, W + 1};
    tbl[9]  = '{2'd2, 32'h8000_0000,  32'd1,         32'h8000_0000, 1'b0, W + 2};
    tbl[10] = '{2'd2, 32'd7,          32'hFFFF_FFF9, 32'hFFFF_FFFF, 1'b0, W + 2};
    tbl[11] = '{2'd2, 32'd3,          32'd7,         32'd0,         1'b0, W + 2};

    repeat (3) @(negedge clk);
    check_all_zero("reset");
    clr_n = 1'b1;
    chk_en = 1'b1;

    foreach (tbl[i]) begin
      run_op(tbl[i].op, tbl[i].a, tbl[i].b, tbl[i].exp_res, tbl[i].exp_exc, tbl[i].lat,
             $sformatf("vec%0d", i));
    end

    for (int i = 0; i < 10; i++) begin
      op = 2'($urandom_range(1, 2));
      a  = (i % 3 == 0) ? W'($urandom_range(0, 1000)) - W'(500) : $urandom;
      b  = (i % 4 == 0) ? W'($urandom_range(0, 20)) : $urandom;
      model(op, a, b, r, e, lat);
      run_op(op, a, b, r, e, lat, $sformatf("rnd%0d", i));
    end

    // Restart: a divide arriving 5 cycles into a multiply replaces it.
    pulse(2'd1, 32'd7, 32'hFFFF_FFFD);
    repeat (4) @(posedge clk);
    run_op(2'd2, 32'd9, 32'd3, 32'd3, 1'b0, W + 2, "abort");

    // Reset 10 cycles into a multiply: everything clears and no result appears.
    pulse(2'd1, 32'd123, 32'd456);
    repeat (9) @(posedge clk);
    @(negedge clk);
    clr_n = 1'b0;
    @(negedge clk);
    check_all_zero("midreset");
    clr_n = 1'b1;
    repeat (W + 8) @(negedge clk);
    run_op(2'd1, 32'd123, 32'd456, 32'd56088, 1'b0, W + 1, "post_reset");

    repeat (3) @(negedge clk);
    check_val("queue_empty", 32'(exp_q.size()), 32'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
